// File: rtl/hall_call_dispatcher.sv
// Hall call dispatcher: latches hall calls into up/down pending vectors and
// offers them one at a time to a lift chosen by the priority controller.
// Entries are indexed {dir,floor}; a round-robin pointer picks the next one.
// Optional feature: define ACK_TIMEOUT_EN to abandon an offer that is not
// acknowledged within 15 ISSUE cycles (the call stays pending).
module hall_call_dispatcher (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_valid,
  input  logic [2:0] call_floor,
  input  logic       call_dir,
  input  logic [1:0] selected_lift,
  input  logic       ack_L1,
  input  logic       ack_L2,
  output logic [2:0] req_floor,
  output logic       req_direction,
  output logic       assign_valid_L1,
  output logic       assign_valid_L2,
  output logic [2:0] assign_floor,
  output logic       assign_dir,
  output logic [7:0] pending_up,
  output logic [7:0] pending_down,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StSelect, StIssue} state_e;

  state_e      state_q;
  logic [3:0]  ptr_q;
  logic [3:0]  cur_idx_q;

  logic [15:0] pend;
  logic [15:0] call_vec;
  logic [15:0] clear_vec;
  logic [15:0] pend_d;
  logic        call_ok;
  logic        ack_hit;
  logic        timeout;
  logic [3:0]  pick_idx;
  logic        pick_found;
  logic [3:0]  scan_idx;

  // Up entries occupy indices 8..15, down entries 0..7.
  assign pend = {pending_up, pending_down};

  // Up at the top floor and down at the ground floor are meaningless.
  assign call_ok  = call_valid && !(call_dir && (call_floor == 3'd7))
                               && !(!call_dir && (call_floor == 3'd0));
  assign call_vec = call_ok ? (16'd1 << {call_dir, call_floor}) : 16'd0;

  // Only the ack from the lift currently offered counts.
  assign ack_hit   = (state_q == StIssue) &&
                     ((assign_valid_L1 && ack_L1) || (assign_valid_L2 && ack_L2));
  // Clear is applied after the new call, so a same-cycle call for cur_idx is dropped.
  assign clear_vec = ack_hit ? (16'd1 << cur_idx_q) : 16'd0;
  assign pend_d    = (pend | call_vec) & ~clear_vec;

  // Round-robin search: first set entry at or after ptr, wrapping 15 -> 0.
  always_comb begin
    pick_idx   = 4'd0;
    pick_found = 1'b0;
    scan_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr_q + 4'(i);
      if (!pick_found && pend[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

`ifdef ACK_TIMEOUT_EN
  logic [3:0] to_cnt_q;

  // Count unacknowledged ISSUE cycles; the 15th one abandons the offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= 4'd0;
    end else if (state_q == StSelect) begin
      to_cnt_q <= 4'd0;
    end else if ((state_q == StIssue) && !ack_hit) begin
      to_cnt_q <= to_cnt_q + 4'd1;
    end
  end

  assign timeout = (state_q == StIssue) && !ack_hit && (to_cnt_q == 4'd14);
`else
  assign timeout = 1'b0;
`endif

  // Pending latch plus IDLE/SELECT/ISSUE control with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      pending_up      <= 8'd0;
      pending_down    <= 8'd0;
      ptr_q           <= 4'd0;
      cur_idx_q       <= 4'd0;
      req_floor       <= 3'd0;
      req_direction   <= 1'b0;
      assign_floor    <= 3'd0;
      assign_dir      <= 1'b0;
      assign_valid_L1 <= 1'b0;
      assign_valid_L2 <= 1'b0;
      busy            <= 1'b0;
    end else begin
      {pending_up, pending_down} <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            req_floor     <= pick_idx[2:0];
            req_direction <= pick_idx[3];
            cur_idx_q     <= pick_idx;
            busy          <= 1'b1;
            state_q       <= StSelect;
          end
        end
        StSelect: begin
          case (selected_lift)
            2'b01: begin
              assign_valid_L1 <= 1'b1;
              assign_floor    <= req_floor;
              assign_dir      <= req_direction;
              state_q         <= StIssue;
            end
            2'b10: begin
              assign_valid_L2 <= 1'b1;
              assign_floor    <= req_floor;
              assign_dir      <= req_direction;
              state_q         <= StIssue;
            end
            default: begin
              // No lift available: skip past this entry, leave it pending.
              ptr_q   <= cur_idx_q + 4'd1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          endcase
        end
        StIssue: begin
          if (ack_hit || timeout) begin
            assign_valid_L1 <= 1'b0;
            assign_valid_L2 <= 1'b0;
            ptr_q           <= cur_idx_q + 4'd1;
            busy            <= 1'b0;
            state_q         <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher. A small stand-in for the
// priority controller (L1 travelling 2->5, L2 parked at 3) drives selected_lift.
module tb_hall_call_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       call_valid;
  logic [2:0] call_floor;
  logic       call_dir;
  logic [1:0] selected_lift;
  logic       ack_L1;
  logic       ack_L2;
  logic [2:0] req_floor;
  logic       req_direction;
  logic       assign_valid_L1;
  logic       assign_valid_L2;
  logic [2:0] assign_floor;
  logic       assign_dir;
  logic [7:0] pending_up;
  logic [7:0] pending_down;
  logic       busy;
  logic       force_none;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hall_call_dispatcher dut (
    .clk             (clk),
    .rst             (rst),
    .call_valid      (call_valid),
    .call_floor      (call_floor),
    .call_dir        (call_dir),
    .selected_lift   (selected_lift),
    .ack_L1          (ack_L1),
    .ack_L2          (ack_L2),
    .req_floor       (req_floor),
    .req_direction   (req_direction),
    .assign_valid_L1 (assign_valid_L1),
    .assign_valid_L2 (assign_valid_L2),
    .assign_floor    (assign_floor),
    .assign_dir      (assign_dir),
    .pending_up      (pending_up),
    .pending_down    (pending_down),
    .busy            (busy)
  );

  // Priority controller stand-in: L1 takes up calls on its 2..5 path, else L2.
  always_comb begin
    if (force_none) begin
      selected_lift = 2'b00;
    end else if (req_direction && (req_floor >= 3'd2) && (req_floor <= 3'd5)) begin
      selected_lift = 2'b01;
    end else begin
      selected_lift = 2'b10;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic call(input logic [2:0] f, input logic d);
    call_valid = 1'b1;
    call_floor = f;
    call_dir   = d;
  endtask

  initial begin
    rst        = 1'b1;
    call_valid = 1'b0;
    call_floor = 3'd0;
    call_dir   = 1'b0;
    ack_L1     = 1'b0;
    ack_L2     = 1'b0;
    force_none = 1'b0;
    tick;
    tick;
    check("rst_pend_up", pending_up, 8'h00);
    check("rst_pend_dn", pending_down, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_valid", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h00);
    rst = 1'b0;

    // Floor 4 up -> L1, two edges after the call.
    call(3'd4, 1'b1);
    tick;
    call_valid = 1'b0;
    check("s1_latch", pending_up, 8'h10);
    check("s1_busy0", {7'd0, busy}, 8'h00);
    tick;
    check("s1_busy1", {7'd0, busy}, 8'h01);
    check("s1_req", {4'd0, req_direction, req_floor}, {4'd0, 1'b1, 3'd4});
    check("s1_novalid", {7'd0, assign_valid_L1}, 8'h00);
    tick;
    check("s1_valid", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h02);
    check("s1_assign", {4'd0, assign_dir, assign_floor}, {4'd0, 1'b1, 3'd4});
    // Duplicate call merges; wrong-lift ack ignored.
    call(3'd4, 1'b1);
    ack_L2 = 1'b1;
    tick;
    check("s1_dup", pending_up, 8'h10);
    check("s1_wrongack", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h02);
    // Ack with a same-cycle call for the same entry: clear wins.
    ack_L2 = 1'b0;
    ack_L1 = 1'b1;
    tick;
    call_valid = 1'b0;
    ack_L1     = 1'b0;
    check("s1_acked", {7'd0, assign_valid_L1}, 8'h00);
    check("s1_clear", pending_up, 8'h00);
    check("s1_idle", {7'd0, busy}, 8'h00);
    tick;
    check("s1_ptr", {4'd0, dut.ptr_q}, 8'd13);

    // Meaningless calls are ignored.
    call(3'd7, 1'b1);
    tick;
    call(3'd0, 1'b0);
    tick;
    call_valid = 1'b0;
    tick;
    check("s2_up", pending_up, 8'h00);
    check("s2_dn", pending_down, 8'h00);
    check("s2_busy", {7'd0, busy}, 8'h00);

    // 4-up then 2-down: index 12 first, then 2 after wrap.
    call(3'd4, 1'b1);
    tick;
    call(3'd2, 1'b0);
    tick;
    call_valid = 1'b0;
    check("s3_both_dn", pending_down, 8'h04);
    check("s3_req1", {4'd0, req_direction, req_floor}, {4'd0, 1'b1, 3'd4});
    tick;
    check("s3_valid1", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h02);
    ack_L1 = 1'b1;
    tick;
    ack_L1 = 1'b0;
    check("s3_clr1", pending_up, 8'h00);
    check("s3_busy0", {7'd0, busy}, 8'h00);
    tick;
    check("s3_req2", {4'd0, req_direction, req_floor}, {4'd0, 1'b0, 3'd2});
    tick;
    check("s3_valid2", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h01);
    check("s3_assign2", {4'd0, assign_dir, assign_floor}, {4'd0, 1'b0, 3'd2});
    ack_L2 = 1'b1;
    tick;
    ack_L2 = 1'b0;
    check("s3_clr2", pending_down, 8'h00);
    check("s3_ptr", {4'd0, dut.ptr_q}, 8'd3);

    // No lift available: skip index 5, retry next pending index 14.
    force_none = 1'b1;
    call(3'd5, 1'b0);
    tick;
    call(3'd6, 1'b1);
    tick;
    call_valid = 1'b0;
    check("s4_sel5", {4'd0, req_direction, req_floor}, {4'd0, 1'b0, 3'd5});
    tick;
    check("s4_back_idle", {7'd0, busy}, 8'h00);
    check("s4_kept", pending_down, 8'h20);
    check("s4_ptr", {4'd0, dut.ptr_q}, 8'd6);
    force_none = 1'b0;
    tick;
    check("s4_retry", {4'd0, req_direction, req_floor}, {4'd0, 1'b1, 3'd6});
    check("s4_busy", {7'd0, busy}, 8'h01);
    tick;
    check("s4_valid_l2", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h01);

    // Reset during ISSUE, overriding a call and an ack.
    rst = 1'b1;
    call(3'd3, 1'b1);
    ack_L2 = 1'b1;
    tick;
    rst        = 1'b0;
    call_valid = 1'b0;
    ack_L2     = 1'b0;
    check("s5_valid", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h00);
    check("s5_pend_up", pending_up, 8'h00);
    check("s5_pend_dn", pending_down, 8'h00);
    check("s5_busy", {7'd0, busy}, 8'h00);
    check("s5_outs", {1'b0, req_direction, req_floor, assign_dir, assign_floor},
          8'h00);
    check("s5_ptr", {4'd0, dut.ptr_q}, 8'd0);

    // Unacknowledged offer: floor 3 up -> L1.
    call(3'd3, 1'b1);
    tick;
    call_valid = 1'b0;
    tick;
    tick;
    check("s6_valid", {6'd0, assign_valid_L1, assign_valid_L2}, 8'h02);
`ifdef ACK_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick;
    check("s6_still", {7'd0, assign_valid_L1}, 8'h01);
    tick;
    check("s6_timeout", {7'd0, assign_valid_L1}, 8'h00);
    check("s6_kept", pending_up, 8'h08);
    check("s6_idle", {7'd0, busy}, 8'h00);
`else
    for (int i = 0; i < 100; i++) begin
      tick;
      check("s6_hold", {4'd0, assign_valid_L1, assign_dir, assign_floor[1:0]},
            {4'd0, 1'b1, 1'b1, 2'd3});
    end
    ack_L1 = 1'b1;
    tick;
    ack_L1 = 1'b0;
    check("s6_clear", pending_up, 8'h00);
    check("s6_idle", {7'd0, busy}, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_call_dispatcher.md
HALL_CALL_DISPATCHER -- requirements
Module: hall_call_dispatcher

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- call_valid  in  1  hall call strobe, one cycle per call
- call_floor  in  3  hall call floor, 0..7
- call_dir  in  1  hall call direction, 1 = up, 0 = down
- selected_lift  in  2  from priority_controller: 00 none, 01 Lift 1, 10 Lift 2, 11 treated as none
- ack_L1, ack_L2  in  1  lift accepts the current assignment
- req_floor  out  3  registered floor presented to priority_controller
- req_direction  out  1  registered direction presented to priority_controller
- assign_valid_L1, assign_valid_L2  out  1  assignment offered to a lift
- assign_floor  out  3  floor of the offered assignment
- assign_dir  out  1  direction of the offered assignment
- pending_up, pending_down  out  8  latched hall calls, bit index = floor
- busy  out  1  FSM not in IDLE

Function
REQ-003 The block SHALL latch a call into pending_up[call_floor] or pending_down[call_floor] at the edge sampling call_valid=1; call_valid is always accepted.
REQ-004 The block SHALL ignore an up call at floor 7 and a down call at floor 0.
REQ-005 Duplicate calls SHALL merge into the already-set bit.
REQ-006 Pending entries SHALL be indexed 0..15 as {dir,floor}. A 4-bit round-robin pointer, ptr, SHALL choose the first set entry at or after ptr, wrapping 15->0.
REQ-007 The FSM SHALL have states IDLE, SELECT and ISSUE.
REQ-008 IDLE: if any pending bit is set, the FSM SHALL load req_floor, req_direction and cur_idx with the chosen entry and go to SELECT; otherwise it SHALL stay in IDLE.
REQ-009 SELECT lasts exactly one cycle: the FSM SHALL sample selected_lift at its closing edge.
- 01 or 10: go to ISSUE, load assign_floor and assign_dir, assert the matching assign_valid.
- 00 or 11: set ptr=cur_idx+1 and return to IDLE; the pending bit stays set.
REQ-010 ISSUE: exactly one assign_valid SHALL be high, and it and assign_floor/assign_dir SHALL be stable until the matching ack.
- On the matching ack: clear the pending bit, deassert assign_valid at the same edge, set ptr=cur_idx+1, go to IDLE.
- An ack from the non-selected lift SHALL be ignored.
REQ-011 Latency: for a call sampled at edge k with the FSM in IDLE, SELECT SHALL be entered at edge k+1 and assign_valid SHALL be asserted from edge k+2.
REQ-012 If a new call for cur_idx arrives in the same cycle as the accepting ack, the clear SHALL win and the bit SHALL end cleared.
REQ-013 A call for any other entry SHALL be latched in any state without disturbing the FSM.
REQ-014 busy SHALL be 1 in SELECT and ISSUE and 0 in IDLE.

Reset
REQ-015 While rst=1 at an edge, the block SHALL clear pending_up, pending_down, ptr, cur_idx, req_floor, req_direction, assign_floor, assign_dir, assign_valid_L1, assign_valid_L2 and busy, and enter IDLE.
REQ-016 Reset SHALL override call_valid and ack in the same cycle.
REQ-017 Reset during ISSUE SHALL drop assign_valid at that edge and discard all pending calls.

Configuration
REQ-018 With ACK_TIMEOUT_EN defined, a 4-bit counter SHALL clear on ISSUE entry and increment each ISSUE cycle without an ack.
- On reaching 15 with no ack: deassert assign_valid, keep the pending bit set, set ptr=cur_idx+1, return to IDLE.
REQ-019 With ACK_TIMEOUT_EN undefined, the block SHALL wait in ISSUE indefinitely and no counter logic SHALL exist.

Verification
REQ-020 The bench SHALL cover these scenarios, with priority_controller connected, L1 2->5 and L2 3->3:
- Call floor 4 up -> assign_valid_L1=1 two edges after the call, assign_floor=4, assign_dir=1; ack_L1 -> pending_up[4]=0, busy=0 next cycle.
- Up call at floor 7 and down call at floor 0 -> pending_up and pending_down stay 00000000; busy stays 0.
- Calls 4-up and 2-down on consecutive cycles with acks -> served in index order 4-up (index 12) then 2-down (index 2) after wrap; ptr ends at 3.
- selected_lift forced to 00 -> FSM returns to IDLE, the bit stays set, and the FSM retries the next pending index.
- rst asserted while assign_valid_L2=1 -> next cycle all outputs are 0 and the state is IDLE.
- ACK_TIMEOUT_EN defined, no ack -> assign_valid drops after 15 ISSUE cycles and the bit stays set. ACK_TIMEOUT_EN undefined, same stimulus -> assign_valid is held for 100 cycles.
